// File: rtl/row_scanout_pkg.sv
// Shared timing constants and pixel type for the double-buffered VGA row scan-out.
package row_scanout_pkg;

   typedef logic [9:0] cnt_t;

   localparam cnt_t H_ACTIVE = 10'd640;
   localparam cnt_t H_FP     = 10'd16;
   localparam cnt_t H_SYNC   = 10'd96;
   localparam cnt_t H_BP     = 10'd48;
   localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam cnt_t V_ACTIVE = 10'd480;
   localparam cnt_t V_FP     = 10'd10;
   localparam cnt_t V_SYNC   = 10'd2;
   localparam cnt_t V_BP     = 10'd33;

   localparam cnt_t ROW_W    = 10'd512;
   localparam int   COL_BITS = 9;
   typedef logic [COL_BITS-1:0] col_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam pixel_t BLACK       = '0;
   localparam logic   SYNC_ACTIVE = 1'b0;

   function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t len);
      return (x >= lo) && (x < cnt_t'(lo + len));
   endfunction

endpackage

// File: rtl/row_scanout_if.sv
// Drawer write port and VGA output bundle of the row scan-out stage.
interface row_scanout_if;
   import row_scanout_pkg::*;

   col_t       draw_addr;
   pixel_t     draw_data;
   logic       draw_wren;
   logic       swap;
   logic       next_screen;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;

   modport master (
      output draw_addr, draw_data, draw_wren,
      input  swap, next_screen, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
   );

   modport slave (
      input  draw_addr, draw_data, draw_wren,
      output swap, next_screen, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
   );
endinterface

// File: rtl/row_scanout_ram.sv
// One 512x24 row bank: simple dual-port RAM with a single-cycle registered read.
module row_ram
   import row_scanout_pkg::*;
(
   input  logic   clk,
   input  logic   we,
   input  col_t   waddr,
   input  pixel_t wdata,
   input  col_t   raddr,
   output pixel_t rdata
);

   pixel_t mem [ROW_W];

   // NOTE: the array has no reset; the scan-out clears each pixel behind the beam instead.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/row_scanout.sv
// 640x480@60 scan-out of one row bank while the drawer fills the other; banks swap every line.
module row_scanout
   import row_scanout_pkg::*;
#(
   // Vertical timing may be overridden to shorten the frame.
   parameter cnt_t VIS_LINES = V_ACTIVE,
   parameter cnt_t V_FRONT   = V_FP,
   parameter cnt_t V_SYNC_W  = V_SYNC,
   parameter cnt_t V_BACK    = V_BP
) (
   input  logic         clk,
   input  logic         reset,
   row_scanout_if.slave bus
);

   localparam cnt_t V_TOTAL = VIS_LINES + V_FRONT + V_SYNC_W + V_BACK;

   cnt_t   h, v;
   logic   phase, disp_bank;
   logic   swap_q, next_screen_q, hs_q, vs_q, blank_n_q;
   pixel_t rgb_q;
   pixel_t rd [2];
   logic   in_buf, clear_we;

   assign in_buf   = (h < ROW_W) && (v < VIS_LINES);
   // A clear write pending on a reset edge is dropped.
   assign clear_we = phase && in_buf && !reset;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic is_disp;
      assign is_disp = (disp_bank == 1'(b));

      row_ram u_ram (
         .clk   (clk),
         .we    (is_disp ? clear_we : bus.draw_wren),
         .waddr (is_disp ? h[COL_BITS-1:0] : bus.draw_addr),
         .wdata (is_disp ? BLACK : bus.draw_data),
         .raddr (h[COL_BITS-1:0]),
         .rdata (rd[b])
      );
   end

   // NOTE: every register here is assigned with <= so all of them see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         h             <= '0;
         v             <= '0;
         phase         <= 1'b0;
         disp_bank     <= 1'b0;
         swap_q        <= 1'b0;
         next_screen_q <= 1'b0;
         rgb_q         <= BLACK;
         hs_q          <= ~SYNC_ACTIVE;
         vs_q          <= ~SYNC_ACTIVE;
         blank_n_q     <= 1'b0;
      end else begin
         phase         <= ~phase;
         swap_q        <= 1'b0;
         next_screen_q <= 1'b0;
         if (phase) begin
            rgb_q     <= in_buf ? rd[disp_bank] : BLACK;
            hs_q      <= in_window(h, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q      <= in_window(v, VIS_LINES + V_FRONT, V_SYNC_W) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            blank_n_q <= (h < H_ACTIVE) && (v < VIS_LINES);
            if (h == H_ACTIVE - 1'b1 && v < VIS_LINES) begin
               swap_q    <= 1'b1;
               disp_bank <= ~disp_bank;
            end
            if (h == H_TOTAL - 1'b1) begin
               h <= '0;
               if (v == VIS_LINES - 1'b1) next_screen_q <= 1'b1;
               v <= (v == V_TOTAL - 1'b1) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   assign bus.swap        = swap_q;
   assign bus.next_screen = next_screen_q;
   assign bus.vga_r       = rgb_q.r;
   assign bus.vga_g       = rgb_q.g;
   assign bus.vga_b       = rgb_q.b;
   assign bus.vga_hs      = hs_q;
   assign bus.vga_vs      = vs_q;
   assign bus.vga_blank_n = blank_n_q;

endmodule
